// File: rtl/cpu_defs.sv
// Shared CPU constants: sequencer states, opcodes, ALU function codes and IR field positions.
// The ALU and assembler tests import this same package.
package cpu_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SHR  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SHR = 4'd3;
  localparam logic [3:0] ALU_SHL = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_ROR = 4'd7;
  localparam logic [3:0] ALU_ROL = 4'd8;
  localparam logic [3:0] ALU_MUL = 4'd9;
  localparam logic [3:0] ALU_DIV = 4'd10;
  localparam logic [3:0] ALU_NEG = 4'd11;
  localparam logic [3:0] ALU_NOT = 4'd12;

  localparam int unsigned IR_OPC_HI = 31;
  localparam int unsigned IR_OPC_LO = 27;
  localparam int unsigned IR_RA_HI  = 26;
  localparam int unsigned IR_RA_LO  = 23;
  localparam int unsigned IR_RB_HI  = 22;
  localparam int unsigned IR_RB_LO  = 19;
  localparam int unsigned IR_RC_HI  = 18;
  localparam int unsigned IR_RC_LO  = 15;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier: ALU function plus instruction-class flags.
module op_decode
  import cpu_defs::*;
(
  input  logic [4:0] i_opcode,
  output logic [3:0] o_alu_op,
  output logic       o_is_unary,
  output logic       o_is_muldiv,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  always_comb begin
    o_alu_op     = ALU_NOP;
    o_is_unary   = 1'b0;
    o_is_muldiv  = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opcode)
      OP_ADD:  o_alu_op = ALU_ADD;
      OP_SUB:  o_alu_op = ALU_SUB;
      OP_SHR:  o_alu_op = ALU_SHR;
      OP_SHL:  o_alu_op = ALU_SHL;
      OP_AND:  o_alu_op = ALU_AND;
      OP_OR:   o_alu_op = ALU_OR;
      OP_ROR:  o_alu_op = ALU_ROR;
      OP_ROL:  o_alu_op = ALU_ROL;
      OP_MUL: begin
        o_alu_op    = ALU_MUL;
        o_is_muldiv = 1'b1;
      end
      OP_DIV: begin
        o_alu_op    = ALU_DIV;
        o_is_muldiv = 1'b1;
      end
      OP_NEG: begin
        o_alu_op   = ALU_NEG;
        o_is_unary = 1'b1;
      end
      OP_NOT: begin
        o_alu_op   = ALU_NOT;
        o_is_unary = 1'b1;
      end
      OP_HALT: o_is_halt = 1'b1;
      default: o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the single-bus datapath.
// Moore strobes decoded from the state register, with IR fields steering T3-T6.
module control_unit
  import cpu_defs::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic        Stop,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zhiout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Rin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [3:0]  RegSel,
  output logic [3:0]  AluOp,
  output logic        Halted,
  output logic        IllegalOp
);

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;

  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic [3:0] w_alu_op;
  logic       w_is_unary;
  logic       w_is_muldiv;
  logic       w_is_halt;
  logic       w_is_illegal;
  logic       w_end_state;

  assign w_ra = IR[IR_RA_HI:IR_RA_LO];
  assign w_rb = IR[IR_RB_HI:IR_RB_LO];
  assign w_rc = IR[IR_RC_HI:IR_RC_LO];

  op_decode u_op_decode (
    .i_opcode     (IR[IR_OPC_HI:IR_OPC_LO]),
    .o_alu_op     (w_alu_op),
    .o_is_unary   (w_is_unary),
    .o_is_muldiv  (w_is_muldiv),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state   <= ST_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && Run)
        r_illegal <= 1'b0;
      else if (r_state == ST_T3 && w_is_illegal)
        r_illegal <= 1'b1;
    end
  end

  // Visible during the offending T3 itself, then held by the sticky register.
  assign IllegalOp = r_illegal | ((r_state == ST_T3) & w_is_illegal);

  // Stop is only ever consulted at the last state of an instruction.
  assign w_end_state = ((r_state == ST_T5) & ~w_is_muldiv) | (r_state == ST_T6) |
                       ((r_state == ST_T3) & w_is_illegal);

  always_comb begin
    w_next  = r_state;
    PCout   = 1'b0;
    Zhiout  = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    Rout    = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Rin     = 1'b0;
    HIin    = 1'b0;
    LOin    = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    RegSel  = '0;
    AluOp   = ALU_NOP;
    Halted  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        Halted = 1'b1;
        if (Run) w_next = ST_T0;
      end
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        w_next = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        w_next  = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        w_next = ST_T3;
      end
      ST_T3: begin
        if (w_is_halt) begin
          w_next = ST_IDLE;
        end else if (w_is_illegal) begin
          w_next = ST_T0;
        end else begin
          Rout   = 1'b1;
          RegSel = w_rb;
          Yin    = 1'b1;
          w_next = ST_T4;
        end
      end
      ST_T4: begin
        Zin   = 1'b1;
        AluOp = w_alu_op;
        if (!w_is_unary) begin
          Rout   = 1'b1;
          RegSel = w_rc;
        end
        w_next = ST_T5;
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (w_is_muldiv) begin
          LOin   = 1'b1;
          w_next = ST_T6;
        end else begin
          Rin    = 1'b1;
          RegSel = w_ra;
          w_next = ST_T0;
        end
      end
      ST_T6: begin
        Zhiout = 1'b1;
        HIin   = 1'b1;
        w_next = ST_T0;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_end_state && Stop) w_next = ST_IDLE;
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: expected strobe sequences are built per instruction
// from the opcode class and compared cycle by cycle on the falling clock edge.
module tb_control_unit;
  import cpu_defs::*;

  typedef struct packed {
    logic [15:0] s;
    logic [3:0]  rs;
    logic [3:0]  op;
    logic        h;
    logic        ill;
  } exp_t;

  localparam logic [15:0] M_PCOUT  = 16'h8000;
  localparam logic [15:0] M_ZHI    = 16'h4000;
  localparam logic [15:0] M_ZLO    = 16'h2000;
  localparam logic [15:0] M_MDROUT = 16'h1000;
  localparam logic [15:0] M_ROUT   = 16'h0800;
  localparam logic [15:0] M_MARIN  = 16'h0400;
  localparam logic [15:0] M_PCIN   = 16'h0200;
  localparam logic [15:0] M_MDRIN  = 16'h0100;
  localparam logic [15:0] M_IRIN   = 16'h0080;
  localparam logic [15:0] M_YIN    = 16'h0040;
  localparam logic [15:0] M_ZIN    = 16'h0020;
  localparam logic [15:0] M_RIN    = 16'h0010;
  localparam logic [15:0] M_HIIN   = 16'h0008;
  localparam logic [15:0] M_LOIN   = 16'h0004;
  localparam logic [15:0] M_INCPC  = 16'h0002;
  localparam logic [15:0] M_READ   = 16'h0001;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Run   = 1'b0;
  logic        Stop  = 1'b0;
  logic [31:0] IR    = '0;
  logic PCout, Zhiout, Zlowout, MDRout, Rout, MARin, PCin, MDRin, IRin, Yin, Zin, Rin;
  logic HIin, LOin, IncPC, Read, Halted, IllegalOp;
  logic [3:0] RegSel, AluOp;

  int checks   = 0;
  int failures = 0;

  bit   m_idle = 1'b1;
  bit   m_ill  = 1'b0;
  bit   m_halt = 1'b0;
  exp_t exp_q[$];

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Stop(Stop), .IR(IR),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Rin(Rin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .RegSel(RegSel), .AluOp(AluOp), .Halted(Halted), .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic exp_t cur();
    exp_t x;
    x.s   = {PCout, Zhiout, Zlowout, MDRout, Rout, MARin, PCin, MDRin,
             IRin, Yin, Zin, Rin, HIin, LOin, IncPC, Read};
    x.rs  = RegSel;
    x.op  = AluOp;
    x.h   = Halted;
    x.ill = IllegalOp;
    return x;
  endfunction

  // RegSel carries meaning only while a register is driving or loading the bus.
  function automatic exp_t norm(input exp_t x);
    exp_t y;
    y = x;
    if ((x.s & (M_ROUT | M_RIN)) == 16'h0) y.rs = '0;
    return y;
  endfunction

  function automatic exp_t mk(input logic [15:0] s, input logic [3:0] rs, input logic [3:0] op,
                              input logic h, input logic ill);
    exp_t x;
    x.s = s; x.rs = rs; x.op = op; x.h = h; x.ill = ill;
    return x;
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      5'd1:    return ALU_ADD;
      5'd2:    return ALU_SUB;
      5'd3:    return ALU_SHR;
      5'd4:    return ALU_SHL;
      5'd5:    return ALU_AND;
      5'd6:    return ALU_OR;
      5'd7:    return ALU_ROR;
      5'd8:    return ALU_ROL;
      5'd9:    return ALU_MUL;
      5'd10:   return ALU_DIV;
      5'd11:   return ALU_NEG;
      5'd12:   return ALU_NOT;
      default: return ALU_NOP;
    endcase
  endfunction

  // Reference: the cycle list an instruction should produce, from its opcode class alone.
  task automatic build(input logic [31:0] ir);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit legal, unary, muldiv;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    legal  = (op >= 5'd1) && (op <= 5'd12);
    unary  = (op == 5'd11) || (op == 5'd12);
    muldiv = (op == 5'd9) || (op == 5'd10);
    m_halt = (op == 5'd31);
    exp_q.delete();
    exp_q.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 4'd0, 1'b0, m_ill));
    exp_q.push_back(mk(M_ZLO | M_PCIN | M_READ | M_MDRIN, 4'd0, 4'd0, 1'b0, m_ill));
    exp_q.push_back(mk(M_MDROUT | M_IRIN, 4'd0, 4'd0, 1'b0, m_ill));
    if (m_halt) begin
      exp_q.push_back(mk(16'h0, 4'd0, 4'd0, 1'b0, m_ill));
    end else if (!legal) begin
      m_ill = 1'b1;
      exp_q.push_back(mk(16'h0, 4'd0, 4'd0, 1'b0, 1'b1));
    end else begin
      exp_q.push_back(mk(M_ROUT | M_YIN, rb, 4'd0, 1'b0, m_ill));
      if (unary) exp_q.push_back(mk(M_ZIN, 4'd0, alu_of(op), 1'b0, m_ill));
      else       exp_q.push_back(mk(M_ROUT | M_ZIN, rc, alu_of(op), 1'b0, m_ill));
      if (muldiv) begin
        exp_q.push_back(mk(M_ZLO | M_LOIN, 4'd0, 4'd0, 1'b0, m_ill));
        exp_q.push_back(mk(M_ZHI | M_HIIN, 4'd0, 4'd0, 1'b0, m_ill));
      end else begin
        exp_q.push_back(mk(M_ZLO | M_RIN, ra, 4'd0, 1'b0, m_ill));
      end
    end
  endtask

  // Runs one instruction (starting it with Run if idle); Stop toggles randomly until the last cycle.
  task automatic exec_instr(input logic [31:0] ir, input bit stop_end, input string tag);
    int unsigned n;
    exp_t e, a;
    if (m_idle) begin
      n = $urandom_range(2, 0);
      for (int unsigned k = 0; k <= n; k++) begin
        @(negedge Clock);
        e = mk(16'h0, 4'd0, 4'd0, 1'b1, m_ill);
        a = cur();
        checks++;
        if (norm(a) !== norm(e)) begin
          failures++;
          $display("FAIL %s idle%0d: got s=%h rs=%0d op=%0d h=%b ill=%b want s=%h op=%0d h=%b ill=%b",
                   tag, k, a.s, a.rs, a.op, a.h, a.ill, e.s, e.op, e.h, e.ill);
        end
        Run  = (k == n);
        Stop = 1'($urandom_range(1, 0));
      end
      m_ill = 1'b0;
    end
    build(ir);
    for (int unsigned i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      e = exp_q[i];
      a = cur();
      checks++;
      if (norm(a) !== norm(e)) begin
        failures++;
        $display("FAIL %s T%0d ir=%h: got s=%h rs=%0d op=%0d h=%b ill=%b want s=%h rs=%0d op=%0d h=%b ill=%b",
                 tag, i, ir, a.s, a.rs, a.op, a.h, a.ill, e.s, e.rs, e.op, e.h, e.ill);
      end
      Run  = 1'($urandom_range(1, 0));
      Stop = (i == exp_q.size() - 1) ? stop_end : 1'($urandom_range(1, 0));
      if (i == 0) IR = $urandom;
      else if (i == 2) IR = ir;
    end
    m_idle = m_halt || stop_end;
  endtask

  task automatic test_reset();
    exp_t a, e;
    @(negedge Clock);
    a = cur();
    e = mk(16'h0, 4'd0, 4'd0, 1'b1, 1'b0);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL reset_hold: got s=%h rs=%0d op=%0d h=%b ill=%b want all 0, h=1",
               a.s, a.rs, a.op, a.h, a.ill);
    end
    Clear = 1'b1;
    @(negedge Clock);
    a = cur();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL reset_release_idle: got s=%h h=%b want s=0000 h=1", a.s, a.h);
    end
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    IR  = 32'h0A920000;
    a = cur();
    e = mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL reset_first_t0: got s=%h h=%b want s=%h h=0", a.s, a.h, e.s);
    end
    repeat (4) @(negedge Clock);
    checks++;
    if (Zin !== 1'b1 || Rout !== 1'b1 || AluOp !== ALU_ADD) begin
      failures++;
      $display("FAIL reset_reach_t4: got Zin=%b Rout=%b AluOp=%0d want 1 1 %0d",
               Zin, Rout, AluOp, ALU_ADD);
    end
    #2 Clear = 1'b0;
    #1;
    a = cur();
    e = mk(16'h0, 4'd0, 4'd0, 1'b1, 1'b0);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL reset_async_midT4: got s=%h rs=%0d op=%0d h=%b ill=%b want all 0, h=1",
               a.s, a.rs, a.op, a.h, a.ill);
    end
    @(negedge Clock);
    Clear  = 1'b1;
    m_idle = 1'b1;
    m_ill  = 1'b0;
  endtask

  task automatic test_directed();
    exec_instr(32'h1A920000, 1'b0, "shr");
    exec_instr(32'h4A920000, 1'b0, "mul");
    exec_instr(32'h62900000, 1'b0, "not");
    exec_instr(32'h0A920000, 1'b1, "add_stop");
    exec_instr(32'h50000000, 1'b0, "div");
    exec_instr(32'hF8000000, 1'b0, "halt");
    exec_instr(32'hE0000000, 1'b0, "illegal");
    exec_instr(32'h5A920000, 1'b1, "neg_stop");
    exec_instr(32'h0A920000, 1'b0, "add_after_illegal");
    exec_instr(32'hF8000000, 1'b1, "halt_stop");
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(12, 1));
      exec_instr({op, 27'($urandom)}, 1'b0, "b2b");
    end
    exec_instr(32'h48000000, 1'b1, "b2b_last");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(9, 0))
        0, 1:    op = 5'($urandom);
        2:       op = 5'd31;
        3:       op = 5'($urandom_range(30, 13));
        default: op = 5'($urandom_range(12, 1));
      endcase
      exec_instr({op, 27'($urandom)}, ($urandom_range(3, 0) == 0), "rand");
    end
  endtask

  task automatic test_clear_illegal();
    exp_t a;
    exec_instr(32'hE0000000, 1'b1, "ill_stop");
    @(negedge Clock);
    Run = 1'b0;
    a = cur();
    checks++;
    if (a.h !== 1'b1 || a.ill !== 1'b1 || a.s !== 16'h0) begin
      failures++;
      $display("FAIL ill_sticky_idle: got s=%h h=%b ill=%b want s=0000 h=1 ill=1", a.s, a.h, a.ill);
    end
    #2 Clear = 1'b0;
    #1;
    checks++;
    if (IllegalOp !== 1'b0 || Halted !== 1'b1) begin
      failures++;
      $display("FAIL ill_cleared_by_reset: got ill=%b h=%b want ill=0 h=1", IllegalOp, Halted);
    end
    @(negedge Clock);
    Clear  = 1'b1;
    m_idle = 1'b1;
    m_ill  = 1'b0;
    exec_instr(32'h0A920000, 1'b1, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_clear_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer for the single-bus CPU datapath. Drives every datapath control strobe: instruction fetch (T0–T2), then register-register ALU execution (T3–T5, plus T6 for multiply/divide). Instructions come from the IR contents the datapath feeds back. Sits beside `Datapath` at CPU top level and replaces the per-state strobe sequencing that benches currently hand-drive.

## Interface
Reset: one clock `Clock`; `Clear` is asynchronous and active-low (0 = reset).
- no parameters; widths fixed by ISA (32-bit IR, 16 registers)
- `Clock` in 1 — system clock, rising-edge
- `Clear` in 1 — asynchronous active-low reset
- `Run` in 1 — start/resume; sampled only in IDLE
- `Stop` in 1 — level; halt after current instruction retires
- `IR` in 32 — datapath IR output; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
- `PCout, Zhiout, Zlowout, MDRout, Rout` out 1 — bus drivers
- `MARin, PCin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin` out 1 — register loads
- `IncPC, Read` out 1 — PC increment, memory read
- `RegSel` out 4 — register index for `Rout`/`Rin`
- `AluOp` out 4 — ALU function, valid when `Zin` in T4
- `Halted` out 1 — high in IDLE
- `IllegalOp` out 1 — sticky; set on undefined opcode, cleared by accepted `Run`

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Outputs are Moore: decoded from the registered state, plus IR fields in T3–T6. Every strobe not listed for a state is 0.
- IDLE: `Halted`=1. `Run`=1 → T0.
- T0: `PCout MARin IncPC Zin`.
- T1: `Zlowout PCin Read MDRin`.
- T2: `MDRout IRin`.
- T3: IR is valid.
  - ALU/mul/div op: `Rout`, `RegSel`=Rb, `Yin`.
  - Halt opcode (11111): no strobes; → IDLE.
  - Undefined opcode: no strobes; set `IllegalOp`; → T0, or IDLE if `Stop`.
- T4, binary op: `Rout`, `RegSel`=Rc, `Zin`, `AluOp`.
- T4, unary op (neg, not): `Zin`, `AluOp` only. Rc ignored. `Rout`=0.
- T5:
  - ALU op: `Zlowout Rin`, `RegSel`=Ra. End of instruction.
  - mul/div: `Zlowout LOin`; → T6.
- T6 (mul/div only): `Zhiout HIin`. End of instruction.
- End of instruction: → T0 if `Stop`=0, else IDLE.
- Opcodes: 00001 add, 00010 sub, 00011 shr, 00100 shl, 00101 and, 00110 or, 00111 ror, 01000 rol, 01001 mul, 01010 div, 01011 neg, 01100 not, 11111 halt. All others are undefined.
- `AluOp` encoding is defined in the shared constants; it is held at 0 outside T4.
- Ra=0 is a legal write target; no special-casing.

## Timing
- Each state lasts exactly one `Clock` cycle. Datapath registers capture on the rising edge that ends the state asserting their `*in`.
- Instruction latency: ALU op 6 cycles, mul/div 7, halt 4 (T0–T3), undefined 4.
- Back-to-back instructions: T5/T6 → T0 with no bubble.
- `Stop` is sampled only at the end of an instruction. Asserting it mid-instruction never truncates the instruction.
- `Run` high in the same cycle as a halt opcode has no effect; a fresh `Run` in IDLE is required.
- `Clear` low at any time: immediate IDLE, all strobes 0, `RegSel`=0, `AluOp`=0, `Halted`=1, `IllegalOp`=0. On release the block waits in IDLE for `Run`.
- Reset mid-instruction abandons it; any partial PC increment is not undone.

## Structure
- Shared constants file `cpu_defs` (include/package): state encoding, 5-bit opcode values, `AluOp` codes, IR field bit positions. The ALU and assembler tests use the same file.
- One sub-module, `op_decode`: combinational IR[31:27] → {`AluOp`, is_unary, is_muldiv, is_halt, is_illegal}.
- The `control_unit` top holds the state register, `IllegalOp` flag, and output decode.

## Test plan
- Reset: `Clear`=0 mid-T4 → next sample all strobes 0, `Halted`=1. Release, `Run`=1 → T0 strobes `PCout MARin IncPC Zin` on the following cycle.
- shr fetch/execute: IR=0x1A920000 → T3 `RegSel`=2 `Rout Yin`; T4 `RegSel`=4 `AluOp`=shr `Zin`; T5 `RegSel`=5 `Rin Zlowout`. With `Datapath` bound and R2=12, R4=3 → R5=1.
- mul: IR=0x4A920000 → T5 `LOin Zlowout`, T6 `HIin Zhiout`, `Rin` never asserted; 7 cycles T0→T0.
- unary not: IR=0x62900000 → T4 `Rout`=0, `Zin`=1, `AluOp`=not; T5 writes Ra=5.
- halt/Stop: IR=0xF8000000 → IDLE after T3, `Halted`=1. Separately, `Stop` raised in T4 of an add → add completes T5, then IDLE.
- illegal: IR=0xE0000000 → `IllegalOp`=1 from T3 on, no `Rin`/`Zin`, next state T0. `Run` accepted in IDLE clears the flag.
